// File: rtl/cascade_engine.sv
// Successor cascade detector: keeps an aged anomaly history and matches each new event against a
// programmable precursor->trigger table plus a distinct-code rule. A match drives a held alert and a circuit-breaker load.
module cascade_engine #(
    parameter int HIST_DEPTH = 4,
    parameter int CODE_W     = 3,
    parameter int NUM_PAT    = 4,
    parameter int WINDOW     = 64,
    parameter int HOLD       = 32,
    parameter int DISTINCT_N = 3,
    parameter int FLASH_CODE = 3,
    parameter int CONF_SHIFT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         rule_valid,
    input  logic [CODE_W-1:0]            rule_code,
    input  logic                         ml_valid,
    input  logic [CODE_W-1:0]            ml_code,
    input  logic [7:0]                   ml_conf,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_PAT)-1:0]   cfg_idx,
    input  logic                         cfg_en,
    input  logic [CODE_W-1:0]            cfg_pre,
    input  logic [CODE_W-1:0]            cfg_trig,
    output logic                         cascade_alert,
    output logic [$clog2(NUM_PAT+1)-1:0] cascade_type,
    output logic                         cb_load,
    output logic [7:0]                   cb_param,
    output logic [15:0]                  cascade_count
);

    localparam int IDX_W  = $clog2(NUM_PAT);
    localparam int TYPE_W = $clog2(NUM_PAT + 1);
    localparam int AGE_W  = $clog2(WINDOW + 1);
    localparam int HOLD_W = $clog2(HOLD + 1);
    localparam int NCODES = 1 << CODE_W;
    localparam int CNT_W  = CODE_W + 1;

    logic              pat_en_q   [NUM_PAT];
    logic              pat_en_d   [NUM_PAT];
    logic [CODE_W-1:0] pat_pre_q  [NUM_PAT];
    logic [CODE_W-1:0] pat_pre_d  [NUM_PAT];
    logic [CODE_W-1:0] pat_trig_q [NUM_PAT];
    logic [CODE_W-1:0] pat_trig_d [NUM_PAT];

    logic [CODE_W-1:0] hist_code_q  [HIST_DEPTH];
    logic [CODE_W-1:0] hist_code_d  [HIST_DEPTH];
    logic [AGE_W-1:0]  hist_age_q   [HIST_DEPTH];
    logic [AGE_W-1:0]  hist_age_d   [HIST_DEPTH];
    logic              hist_valid_q [HIST_DEPTH];
    logic              hist_valid_d [HIST_DEPTH];

    logic [CODE_W-1:0] sh_code  [HIST_DEPTH];
    logic [AGE_W-1:0]  sh_age   [HIST_DEPTH];
    logic              sh_valid [HIST_DEPTH];

    logic              alert_q, alert_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic              load_q, load_d;
    logic [7:0]        param_q, param_d;
    logic [15:0]       count_q, count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              rule_evt, ml_evt, dual_evt, any_evt;
    logic [CODE_W-1:0] trigger;
    logic [NCODES-1:0] pre_seen;
    logic [NCODES-1:0] code_seen;
    logic [CNT_W-1:0]  distinct_cnt;
    logic              dist_hit, pat_hit, fire;
    logic [TYPE_W-1:0] pat_idx, fire_type;
    logic [15:0]       conf_wide;
    logic [7:0]        conf_sat;

    always_comb begin
        rule_evt = rule_valid && (rule_code != '0);
        ml_evt   = ml_valid && (ml_code != '0);
        dual_evt = rule_evt && ml_evt;
        any_evt  = rule_evt || ml_evt;
        trigger  = ml_evt ? ml_code : rule_code;

        // On a dual push the rule event counts as a precursor of the ML trigger
        pre_seen = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_valid_q[i]) pre_seen[hist_code_q[i]] = 1'b1;
        end
        if (dual_evt) pre_seen[rule_code] = 1'b1;

        pat_hit = 1'b0;
        pat_idx = '0;
        for (int k = NUM_PAT - 1; k >= 0; k--) begin
            if (pat_en_q[k] && (pat_trig_q[k] == trigger) && pre_seen[pat_pre_q[k]]) begin
                pat_hit = 1'b1;
                pat_idx = TYPE_W'(k);
            end
        end

        code_seen          = pre_seen;
        code_seen[trigger] = 1'b1;
        distinct_cnt       = '0;
        for (int c = 1; c < NCODES; c++) begin
            if (code_seen[c]) distinct_cnt = distinct_cnt + 1'b1;
        end
        dist_hit = (trigger == CODE_W'(FLASH_CODE)) && (distinct_cnt >= CNT_W'(DISTINCT_N));

        fire      = any_evt && !flush && (dist_hit || pat_hit);
        fire_type = dist_hit ? TYPE_W'(NUM_PAT) : pat_idx;

        conf_wide = 16'(ml_conf) << CONF_SHIFT;
        conf_sat  = (conf_wide[15:8] != 8'd0) ? 8'hFF : conf_wide[7:0];
    end

    always_comb begin
        pat_en_d   = pat_en_q;
        pat_pre_d  = pat_pre_q;
        pat_trig_d = pat_trig_q;
        for (int k = 0; k < NUM_PAT; k++) begin
            if (cfg_we && (cfg_idx == IDX_W'(k))) begin
                pat_en_d[k]   = cfg_en;
                pat_pre_d[k]  = cfg_pre;
                pat_trig_d[k] = cfg_trig;
            end
        end
    end

    always_comb begin
        sh_code  = hist_code_q;
        sh_age   = hist_age_q;
        sh_valid = hist_valid_q;
        if (dual_evt) begin
            for (int i = HIST_DEPTH - 1; i >= 2; i--) begin
                sh_code[i]  = hist_code_q[i-2];
                sh_age[i]   = hist_age_q[i-2];
                sh_valid[i] = hist_valid_q[i-2];
            end
            sh_code[1]  = rule_code;
            sh_age[1]   = '0;
            sh_valid[1] = 1'b1;
            sh_code[0]  = ml_code;
            sh_age[0]   = '0;
            sh_valid[0] = 1'b1;
        end else if (any_evt) begin
            for (int i = HIST_DEPTH - 1; i >= 1; i--) begin
                sh_code[i]  = hist_code_q[i-1];
                sh_age[i]   = hist_age_q[i-1];
                sh_valid[i] = hist_valid_q[i-1];
            end
            sh_code[0]  = trigger;
            sh_age[0]   = '0;
            sh_valid[0] = 1'b1;
        end

        // The push cycle itself is age 0, so the aging step applies to fresh entries too
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_code_d[i]  = sh_code[i];
            hist_age_d[i]   = '0;
            hist_valid_d[i] = 1'b0;
            if (sh_valid[i] && ((sh_age[i] + 1'b1) != AGE_W'(WINDOW))) begin
                hist_age_d[i]   = sh_age[i] + 1'b1;
                hist_valid_d[i] = 1'b1;
            end
            if (flush) begin
                hist_code_d[i]  = '0;
                hist_age_d[i]   = '0;
                hist_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        load_d  = fire;
        type_d  = fire ? fire_type : type_q;
        param_d = fire ? conf_sat : param_q;
        count_d = (fire && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
        if (fire) begin
            hold_d  = HOLD_W'(HOLD - 1);
            alert_d = 1'b1;
        end else if (hold_q != '0) begin
            hold_d  = hold_q - 1'b1;
            alert_d = alert_q;
        end else begin
            hold_d  = '0;
            alert_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_PAT; k++) begin
                pat_en_q[k]   <= 1'b0;
                pat_pre_q[k]  <= '0;
                pat_trig_q[k] <= '0;
            end
            pat_en_q[0]   <= 1'b1;
            pat_pre_q[0]  <= CODE_W'(2);
            pat_trig_q[0] <= CODE_W'(3);
            pat_en_q[1]   <= 1'b1;
            pat_pre_q[1]  <= CODE_W'(1);
            pat_trig_q[1] <= CODE_W'(3);
            pat_en_q[2]   <= 1'b1;
            pat_pre_q[2]  <= CODE_W'(5);
            pat_trig_q[2] <= CODE_W'(3);
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_code_q[i]  <= '0;
                hist_age_q[i]   <= '0;
                hist_valid_q[i] <= 1'b0;
            end
            alert_q <= 1'b0;
            type_q  <= '0;
            load_q  <= 1'b0;
            param_q <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            pat_en_q     <= pat_en_d;
            pat_pre_q    <= pat_pre_d;
            pat_trig_q   <= pat_trig_d;
            hist_code_q  <= hist_code_d;
            hist_age_q   <= hist_age_d;
            hist_valid_q <= hist_valid_d;
            alert_q      <= alert_d;
            type_q       <= type_d;
            load_q       <= load_d;
            param_q      <= param_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
        end
    end

    assign cascade_alert = alert_q;
    assign cascade_type  = type_q;
    assign cb_load       = load_q;
    assign cb_param      = param_q;
    assign cascade_count = count_q;

endmodule
